alu_rs: RTL
===========

Name: alu_rs

Overview:
- Reservation station directly upstream of the ALU in the out-of-order core.
- Buffers issued ALU-class instructions from the decoder/issue stage.
- Snoops the two common data buses (ALU, LSB) to resolve operand tags.
- Dispatches at most one ready instruction per cycle, as registered operands, into the single-cycle ALU.

Parameters:
- RS_SIZE, 8, number of entries (power of 2, 2..16).
- TAG_W, 5, ROB tag width.
- OP_W, 5, ALU opcode width (encodings in shared defines).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-low
- rdy_in  input  1  ready; all state frozen when low
- flush_in  input  1  mispredict flush; clears all entries
- issue_valid_in  input  1  new instruction this cycle
- issue_op_in  input  OP_W  ALU opcode
- issue_vj_in  input  32  operand A value (valid when qj not pending)
- issue_qj_valid_in  input  1  operand A waits on tag
- issue_qj_in  input  TAG_W  operand A producer tag
- issue_vk_in  input  32  operand B value or immediate
- issue_qk_valid_in  input  1  operand B waits on tag
- issue_qk_in  input  TAG_W  operand B producer tag
- issue_pc_in  input  32  instruction PC
- issue_dest_in  input  TAG_W  destination ROB tag
- full_out  output  1  no free entry
- cdb_alu_valid_in  input  1  ALU broadcast valid
- cdb_alu_tag_in  input  TAG_W  ALU broadcast tag
- cdb_alu_val_in  input  32  ALU broadcast value
- cdb_lsb_valid_in  input  1  LSB broadcast valid
- cdb_lsb_tag_in  input  TAG_W  LSB broadcast tag
- cdb_lsb_val_in  input  32  LSB broadcast value
- alu_valid_out  output  1  dispatch valid (registered)
- alu_op_out  output  OP_W  opcode
- alu_a_out  output  32  operand A
- alu_b_out  output  32  operand B
- alu_pc_out  output  32  PC
- alu_dest_out  output  TAG_W  destination tag

Behaviour:
- Priority per edge: reset (rst_in=0) > rdy_in=0 (hold everything) > flush_in > normal operation.
- Reset and flush: all busy bits cleared; alu_valid_out=0; other alu_*_out=0 on reset, don't-care after flush. Issue and CDB inputs in the same cycle are dropped.
- Entry fields: busy, op, vj, qj_valid, qj, vk, qk_valid, qk, pc, dest.
- full_out: combinational, high when all RS_SIZE entries are busy (registered state). It does not account for an entry freed by same-cycle dispatch; this is a deliberate conservative choice.
- Issue:
  - When issue_valid_in && !full_out, write the lowest-index free entry.
  - Issue while full_out=1 is a protocol violation and is ignored.
- Issue-time bypass: if issue_qj_valid_in and issue_qj_in matches a valid CDB tag in the same cycle, store that CDB value and clear qj_valid. Same rule for k.
- CDB snoop, every active cycle, each busy entry with a pending operand: on tag match, capture the value and clear the pending bit.
  - If both buses match the same tag, the ALU bus wins. This cannot occur legally.
- Ready entry: busy && !qj_valid && !qk_valid, evaluated on registered state. A value captured at edge t makes the entry ready for selection at edge t+1.
- Dispatch, each active edge:
  - Pick the lowest-index ready entry.
  - Register its op/vj/vk/pc/dest onto alu_*_out, set alu_valid_out=1, clear its busy bit.
  - If none is ready, alu_valid_out=0.
  - The ALU always accepts; there is no back-pressure.
- Latency: instruction issued with both operands ready at edge t gives alu_valid_out high in the cycle after edge t+1. Minimum residency is one cycle.
- Simultaneous issue and dispatch: both apply. A freed entry is reusable from the next edge only.
- rdy_in low: entries, outputs and full_out unchanged. Issue and CDB inputs are ignored; upstream is stalled too.

Decomposition:
- Shared defines file (existing const-style include):
  - TAG_W, OP_W, RS_SIZE defaults.
  - ALU opcode encodings: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, BEQ, BNE, BLT, BGE, BLTU, BGEU, LUI, AUIPC, JAL, JALR.
- One sub-module: rs_select, a parameterised lowest-index priority encoder (valid flag + index). Instantiate it twice: free-entry select on ~busy, dispatch select on ready.

Test Plan:
- Reset: rst_in=0 for 2 cycles with issue_valid_in=1 -> alu_valid_out=0, full_out=0, no entry allocated.
- Ready issue: ADD, vj=5, vk=7, dest=3, no pending tags -> one cycle later alu_valid_out=1, a=5, b=7, dest=3; the next cycle alu_valid_out=0.
- Tag wakeup:
  - Issue SUB with qj=9 pending, vk=1.
  - Two cycles later, cdb_lsb tag=9 val=0x10 -> dispatch exactly one cycle after the broadcast with a=0x10, b=1.
- Same-cycle bypass: issue with qk=4 while cdb_alu tag=4 val=0xAB -> stored ready, dispatches next cycle with b=0xAB.
- Full/ordering:
  - Issue 8 instructions all waiting on tag 2 -> full_out=1; a 9th issue is ignored.
  - Broadcast tag 2 -> entries dispatch in index order 0..7 on 8 consecutive cycles; full_out drops after the first dispatch.
- Stall and flush:
  - rdy_in=0 for 3 cycles mid-operation -> outputs and full_out hold.
  - Then flush_in=1 together with issue_valid_in=1 -> next cycle all entries empty, alu_valid_out=0, full_out=0.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// ============================================================================
// Module : alu_rs_pkg
// Brief  : Shared widths, defaults and ALU opcode encodings for the ALU RS.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_rs_pkg;

    localparam int unsigned c_TAG_W   = 5;
    localparam int unsigned c_OP_W    = 5;
    localparam int unsigned c_RS_SIZE = 8;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_AND   = 5'd2,
        OP_OR    = 5'd3,
        OP_XOR   = 5'd4,
        OP_SLL   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_SLT   = 5'd8,
        OP_SLTU  = 5'd9,
        OP_BEQ   = 5'd10,
        OP_BNE   = 5'd11,
        OP_BLT   = 5'd12,
        OP_BGE   = 5'd13,
        OP_BLTU  = 5'd14,
        OP_BGEU  = 5'd15,
        OP_LUI   = 5'd16,
        OP_AUIPC = 5'd17,
        OP_JAL   = 5'd18,
        OP_JALR  = 5'd19
    } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/alu_rs_select.sv
// ============================================================================
// Module : rs_select
// Brief  : Lowest-index priority encoder returning a hit flag and its index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_select #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top so the lowest set bit is the last (winning) write.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs.sv
// ============================================================================
// Module : alu_rs
// Brief  : ALU reservation station: buffers issued ops, snoops both CDBs and
//          dispatches the lowest-index ready entry into the ALU each cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = c_RS_SIZE,
    parameter int TAG_W   = c_TAG_W,
    parameter int OP_W    = c_OP_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             issue_valid_in,
    input  logic [OP_W-1:0]  issue_op_in,
    input  logic [31:0]      issue_vj_in,
    input  logic             issue_qj_valid_in,
    input  logic [TAG_W-1:0] issue_qj_in,
    input  logic [31:0]      issue_vk_in,
    input  logic             issue_qk_valid_in,
    input  logic [TAG_W-1:0] issue_qk_in,
    input  logic [31:0]      issue_pc_in,
    input  logic [TAG_W-1:0] issue_dest_in,
    output logic             full_out,
    input  logic             cdb_alu_valid_in,
    input  logic [TAG_W-1:0] cdb_alu_tag_in,
    input  logic [31:0]      cdb_alu_val_in,
    input  logic             cdb_lsb_valid_in,
    input  logic [TAG_W-1:0] cdb_lsb_tag_in,
    input  logic [31:0]      cdb_lsb_val_in,
    output logic             alu_valid_out,
    output logic [OP_W-1:0]  alu_op_out,
    output logic [31:0]      alu_a_out,
    output logic [31:0]      alu_b_out,
    output logic [31:0]      alu_pc_out,
    output logic [TAG_W-1:0] alu_dest_out
);

    localparam int c_IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q, busy_d, qjv_q, qjv_d, qkv_q, qkv_d;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [OP_W-1:0]    op_d   [RS_SIZE];
    logic [31:0]        vj_q   [RS_SIZE];
    logic [31:0]        vj_d   [RS_SIZE];
    logic [31:0]        vk_q   [RS_SIZE];
    logic [31:0]        vk_d   [RS_SIZE];
    logic [31:0]        pc_q   [RS_SIZE];
    logic [31:0]        pc_d   [RS_SIZE];
    logic [TAG_W-1:0]   qj_q   [RS_SIZE];
    logic [TAG_W-1:0]   qj_d   [RS_SIZE];
    logic [TAG_W-1:0]   qk_q   [RS_SIZE];
    logic [TAG_W-1:0]   qk_d   [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_d [RS_SIZE];

    logic               alu_valid_q, alu_valid_d;
    logic [OP_W-1:0]    alu_op_q, alu_op_d;
    logic [31:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_pc_q, alu_pc_d;
    logic [TAG_W-1:0]   alu_dest_q, alu_dest_d;

    logic [RS_SIZE-1:0] w_ready;
    logic               w_free_valid, w_disp_valid;
    logic [c_IDX_W-1:0] w_free_idx, w_disp_idx;

    assign w_ready  = busy_q & ~qjv_q & ~qkv_q;
    assign full_out = &busy_q;

    rs_select #(.N(RS_SIZE), .IDX_W(c_IDX_W)) u_free_sel (
        .req_i   (~busy_q),
        .valid_o (w_free_valid),
        .idx_o   (w_free_idx)
    );

    rs_select #(.N(RS_SIZE), .IDX_W(c_IDX_W)) u_disp_sel (
        .req_i   (w_ready),
        .valid_o (w_disp_valid),
        .idx_o   (w_disp_idx)
    );

    function automatic logic tag_hit(input logic v, input logic [TAG_W-1:0] a,
                                     input logic [TAG_W-1:0] b);
        return v && (a == b);
    endfunction

    always_comb begin
        busy_d = busy_q;  qjv_d = qjv_q;  qkv_d = qkv_q;
        op_d   = op_q;    vj_d  = vj_q;   vk_d  = vk_q;   pc_d = pc_q;
        qj_d   = qj_q;    qk_d  = qk_q;   dest_d = dest_q;
        alu_valid_d = w_disp_valid;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_pc_d    = alu_pc_q;
        alu_dest_d  = alu_dest_q;

        // ALU bus is checked first so it wins an (illegal) dual match.
        for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && qjv_q[i]) begin
                if (tag_hit(cdb_alu_valid_in, qj_q[i], cdb_alu_tag_in)) begin
                    vj_d[i] = cdb_alu_val_in;  qjv_d[i] = 1'b0;
                end else if (tag_hit(cdb_lsb_valid_in, qj_q[i], cdb_lsb_tag_in)) begin
                    vj_d[i] = cdb_lsb_val_in;  qjv_d[i] = 1'b0;
                end
            end
            if (busy_q[i] && qkv_q[i]) begin
                if (tag_hit(cdb_alu_valid_in, qk_q[i], cdb_alu_tag_in)) begin
                    vk_d[i] = cdb_alu_val_in;  qkv_d[i] = 1'b0;
                end else if (tag_hit(cdb_lsb_valid_in, qk_q[i], cdb_lsb_tag_in)) begin
                    vk_d[i] = cdb_lsb_val_in;  qkv_d[i] = 1'b0;
                end
            end
        end

        if (w_disp_valid) begin
            busy_d[w_disp_idx] = 1'b0;
            alu_op_d   = op_q[w_disp_idx];
            alu_a_d    = vj_q[w_disp_idx];
            alu_b_d    = vk_q[w_disp_idx];
            alu_pc_d   = pc_q[w_disp_idx];
            alu_dest_d = dest_q[w_disp_idx];
        end

        // The free slot is never the dispatched one, so both updates coexist.
        if (issue_valid_in && !full_out && w_free_valid) begin
            busy_d[w_free_idx] = 1'b1;
            op_d[w_free_idx]   = issue_op_in;
            pc_d[w_free_idx]   = issue_pc_in;
            dest_d[w_free_idx] = issue_dest_in;
            vj_d[w_free_idx]   = issue_vj_in;
            qjv_d[w_free_idx]  = issue_qj_valid_in;
            qj_d[w_free_idx]   = issue_qj_in;
            vk_d[w_free_idx]   = issue_vk_in;
            qkv_d[w_free_idx]  = issue_qk_valid_in;
            qk_d[w_free_idx]   = issue_qk_in;
            if (issue_qj_valid_in) begin
                if (tag_hit(cdb_alu_valid_in, issue_qj_in, cdb_alu_tag_in)) begin
                    vj_d[w_free_idx] = cdb_alu_val_in;  qjv_d[w_free_idx] = 1'b0;
                end else if (tag_hit(cdb_lsb_valid_in, issue_qj_in, cdb_lsb_tag_in)) begin
                    vj_d[w_free_idx] = cdb_lsb_val_in;  qjv_d[w_free_idx] = 1'b0;
                end
            end
            if (issue_qk_valid_in) begin
                if (tag_hit(cdb_alu_valid_in, issue_qk_in, cdb_alu_tag_in)) begin
                    vk_d[w_free_idx] = cdb_alu_val_in;  qkv_d[w_free_idx] = 1'b0;
                end else if (tag_hit(cdb_lsb_valid_in, issue_qk_in, cdb_lsb_tag_in)) begin
                    vk_d[w_free_idx] = cdb_lsb_val_in;  qkv_d[w_free_idx] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q      <= '0;
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_pc_q    <= '0;
            alu_dest_q  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy_q      <= '0;
                alu_valid_q <= 1'b0;
            end else begin
                busy_q      <= busy_d;
                alu_valid_q <= alu_valid_d;
                alu_op_q    <= alu_op_d;
                alu_a_q     <= alu_a_d;
                alu_b_q     <= alu_b_d;
                alu_pc_q    <= alu_pc_d;
                alu_dest_q  <= alu_dest_d;
            end
        end
    end

    // Payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && !flush_in) begin
            qjv_q  <= qjv_d;   qkv_q <= qkv_d;
            op_q   <= op_d;    vj_q  <= vj_d;   vk_q <= vk_d;   pc_q <= pc_d;
            qj_q   <= qj_d;    qk_q  <= qk_d;   dest_q <= dest_d;
        end
    end

    assign alu_valid_out = alu_valid_q;
    assign alu_op_out    = alu_op_q;
    assign alu_a_out     = alu_a_q;
    assign alu_b_out     = alu_b_q;
    assign alu_pc_out    = alu_pc_q;
    assign alu_dest_out  = alu_dest_q;

endmodule

`default_nettype wire
